// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-collector lines via output enables.
// Optional: define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte up to twice before err.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] cmd_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       ready,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_FAIL
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     inh_cnt, inh_n;
  logic [19:0]       to_cnt, to_n;
  logic [20:0]       to_inc;
  logic [3:0]        bit_idx, bit_n;
  logic [8:0]        frame_q, frame_n;
  logic [8:0]        shreg, sh_n;
  logic              clk_oe_n, dat_oe_n, ready_n, done_n, err_n;
  logic              fail_now;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]        retry_cnt, retry_n;
`endif

  // Idle lines float high, so the synchronisers reset to 1 to avoid a false edge.
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, clk_s, dat_s, fe;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_in};
      clk_prev <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];
  assign fe     = clk_prev & ~clk_s;
  assign to_inc = {1'b0, to_cnt} + 21'd1;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      bit_idx    <= '0;
      frame_q    <= '0;
      shreg      <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      state      <= state_n;
      inh_cnt    <= inh_n;
      to_cnt     <= to_n;
      bit_idx    <= bit_n;
      frame_q    <= frame_n;
      shreg      <= sh_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      ready      <= ready_n;
      done       <= done_n;
      err        <= err_n;
`ifdef PS2_TX_RETRY_EN
      retry_cnt  <= retry_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    inh_n    = inh_cnt;
    to_n     = to_cnt;
    bit_n    = bit_idx;
    frame_n  = frame_q;
    sh_n     = shreg;
    clk_oe_n = ps2_clk_oe;
    dat_oe_n = ps2_dat_oe;
    done_n   = 1'b0;
    err_n    = 1'b0;
    fail_now = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n  = retry_cnt;
`endif

    case (state)
      S_IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (send) begin
          frame_n  = {~^cmd_byte, cmd_byte};
          inh_n    = '0;
          clk_oe_n = 1'b1;
          dat_oe_n = (INHIBIT_CYCLES == 1);
          state_n  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_n  = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b1;
          to_n     = '0;
          state_n  = S_REQ;
        end else begin
          inh_n    = inh_cnt + 1'b1;
          // Start bit goes out one cycle early so it overlaps the last inhibit cycle.
          dat_oe_n = (inh_cnt + 1'b1 == IW'(INHIBIT_CYCLES - 1));
        end
      end
      S_REQ: begin
        sh_n    = frame_q;
        bit_n   = '0;
        state_n = S_SEND;
      end
      S_SEND: begin
        if (fe) begin
          if (bit_idx == 4'd9) begin
            dat_oe_n = 1'b0;
            state_n  = S_ACK;
          end else begin
            dat_oe_n = ~shreg[0];
            sh_n     = {1'b0, shreg[8:1]};
            bit_n    = bit_idx + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fe) begin
          if (!dat_s) state_n  = S_WAIT_IDLE;
          else        fail_now = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_FAIL: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Timeout runs across the whole device phase and wins over any same-cycle edge.
    if (state inside {S_REQ, S_SEND, S_ACK, S_WAIT_IDLE}) begin
      to_n = to_inc[20] ? to_cnt : to_inc[19:0];
      if (to_inc >= 21'(TIMEOUT_CYCLES)) fail_now = 1'b1;
    end

    if (fail_now) begin
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      done_n   = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt != 2'd2) begin
        retry_n  = retry_cnt + 2'd1;
        inh_n    = '0;
        clk_oe_n = 1'b1;
        dat_oe_n = (INHIBIT_CYCLES == 1);
        state_n  = S_INHIBIT;
      end else begin
        err_n   = 1'b1;
        state_n = S_FAIL;
      end
`else
      err_n   = 1'b1;
      state_n = S_FAIL;
`endif
    end

    ready_n = (state_n == S_IDLE);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It drives the open-collector PS2_CLK/PS2_DAT lines through separate output-enable signals. It sits beside the PS/2 receiver and shares the same physical lines with it.

Parameters:
INHIBIT_CYCLES, 5000, CLOCK_50 cycles the host holds PS2_CLK low before the request (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum cycles from clock release to ACK sampled (15 ms).
SYNC_STAGES, 2, flip-flop stages synchronising ps2_clk_in and ps2_dat_in (minimum 2).

Ports:
CLOCK_50  input  1  system clock, 50 MHz.
reset_n  input  1  asynchronous, active-low reset.
send  input  1  request strobe; accepted only when ready=1.
cmd_byte  input  8  byte to transmit; latched on accept.
ps2_clk_in  input  1  raw PS2_CLK pad input.
ps2_dat_in  input  1  raw PS2_DAT pad input.
ps2_clk_oe  output  1  1 = pull PS2_CLK low, 0 = release.
ps2_dat_oe  output  1  1 = pull PS2_DAT low, 0 = release.
ready  output  1  high only in IDLE.
done  output  1  one-cycle pulse: byte sent and device ACKed.
err  output  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; ps2_clk_oe=0, ps2_dat_oe=0, ready=1, done=0, err=0; counters and shift register cleared.
  - Asserting reset mid-transfer releases both lines in the same instant, with no clock edge required.
- Input sync: ps2_clk_in passes through a SYNC_STAGES synchroniser. A falling edge (fe) is a synced 1 followed by a synced 0, a one-cycle pulse. ps2_dat_in is synchronised identically.
- Handshake:
  - send=1 while ready=1 latches cmd_byte and computes the odd-parity bit (parity = ~^cmd_byte).
  - ready drops on the next cycle.
  - send while ready=0 is ignored; there is no queueing.
- States:
  - IDLE: lines released. Accept moves to INHIBIT.
  - INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. In the final cycle ps2_dat_oe goes to 1 (start bit). Then go to REQ.
  - REQ: ps2_clk_oe=0, ps2_dat_oe=1. The timeout counter starts. Go to SEND with bit index 0.
  - SEND: on each fe, drive the next bit: ps2_dat_oe = ~bit.
    - fe #1..#8 drive data bits D0..D7, LSB first.
    - fe #9 drives parity.
    - fe #10 releases data (stop bit = 1), then go to ACK.
  - ACK: on fe #11, sample synced data.
    - Data 0 means ACK: go to WAIT_IDLE.
    - Data 1 means NACK: go to FAIL.
  - WAIT_IDLE: wait until synced clock=1 and synced data=1. Then pulse done for 1 cycle and go to IDLE.
  - FAIL: release both lines, pulse err for 1 cycle, go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in REQ, SEND, ACK or WAIT_IDLE, go to FAIL. The counter is 20 bits wide and saturates; it is not reloaded per bit.
- Simultaneous events: an fe and the timeout expiring in the same cycle resolve to timeout (FAIL).
- Outputs: registered. done and err are never high together and never high longer than one cycle.
- fe pulses are ignored in IDLE and INHIBIT.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on NACK or timeout, the block re-enters INHIBIT with the same latched byte, up to 2 retries (3 attempts total).
  - err pulses only after the third failure.
  - ready stays 0 throughout all attempts.
  - The retry counter clears on accept.
- Undefined: the first failure goes straight to FAIL and err. No retry logic is synthesised.

Test Plan:
1. send with cmd_byte=0xED; the bench models a device clocking at 12.5 kHz and sampling on rising edges.
   - Required: ps2_clk_oe high for exactly 5000 cycles.
   - Device decodes data 0xED, parity=1, stop=1.
   - Device drives ACK low, then done pulses once and ready returns to 1.
2. cmd_byte=0xF4 -> parity bit=0. cmd_byte=0xFF -> parity bit=1. Both complete with done.
3. Device never clocks after the request -> err pulses exactly 750000 cycles after clock release and both oe signals are 0.
   - With PS2_TX_RETRY_EN: three inhibit phases occur, then a single err.
4. Device leaves data high on fe #11 (NACK) -> err pulse, no done, lines released.
5. reset_n driven low during fe #5 of a transfer -> both oe signals 0 asynchronously. After release: ready=1, done=0, err=0.
6. send pulsed again during SEND with cmd_byte=0x00 -> ignored; the original byte completes intact and only one done is produced.
